// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one uart_tx between NUM_REQ byte
//            producers. Optional message lock via UART_TX_ARB_LOCK_EN.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] eligible;
  logic [ID_W-1:0]    win;
  logic               win_found;
  logic               accept;
  logic [ID_W-1:0]    ptr_next;

`ifdef UART_TX_ARB_LOCK_EN
  logic            locked;
  logic [ID_W-1:0] lock_id;

  always_comb begin
    eligible = req_valid;
    if (locked) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i != int'(lock_id)) eligible[i] = 1'b0;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign eligible    = req_valid;
`endif

  // Scan downward so the requester closest above ptr overwrites the others.
  always_comb begin
    int idx;
    idx       = 0;
    win       = '0;
    win_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (eligible[idx[ID_W-1:0]]) begin
        win       = idx[ID_W-1:0];
        win_found = 1'b1;
      end
    end
  end

  assign accept   = (state == IDLE) && !tx_busy && win_found && !rst;
  assign ptr_next = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      grant_id <= '0;
      active   <= 1'b0;
      ptr      <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      locked   <= 1'b0;
      lock_id  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data  <= req_data[8*win +: 8];
            grant_id <= win;
            tx_start <= 1'b1;
            active   <= 1'b1;
            state    <= START;
`ifdef UART_TX_ARB_LOCK_EN
            if (req_last[win]) begin
              locked <= 1'b0;
              ptr    <= ptr_next;
            end else begin
              locked  <= 1'b1;
              lock_id <= win;
            end
`else
            ptr <= ptr_next;
`endif
          end
        end
        START: begin
          tx_start <= 1'b0;
          state    <= WAIT_BUSY;
        end
        // uart_tx raises busy one cycle after it sees the start pulse.
        WAIT_BUSY: begin
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          tx_start <= 1'b0;
          active   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter with a uart_tx busy model
//            and a queue-based round-robin reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int FRAME   = 20;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [ID_W-1:0]      grant_id;
  logic                 active;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id), .active(active)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy from the cycle after tx_start for FRAME cycles, unaffected by rst.
  int busy_cnt = 0;
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (tx_start === 1'b1) busy_cnt <= FRAME;
  end

  // Producer queues and reference-model state.
  logic [7:0] dq[NUM_REQ][$];
  bit         lq[NUM_REQ][$];
  int         glog[$];
  logic [7:0] dlog[$];
  int         m_ptr, m_lock;
  bit         m_locked, m_out, m_seen, gaps;

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 0; m_lock = 0; m_locked = 0; m_out = 0; m_seen = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((active !== 1'b0 || tx_busy !== 1'b0) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: active=%b tx_busy=%b after %0d cycles, need idle", name, active, tx_busy, n);
    end
  endtask

  // Drives queues as requesters and checks every cycle against the reference.
  task automatic run_traffic(input string name, input int budget);
    bit         pend, done, lastb;
    int         pend_id, exp_w, idx;
    logic [7:0] pend_byte;
    logic [NUM_REQ-1:0] elig, exp_ready;
    pend = 0; done = 0; pend_id = 0; pend_byte = 0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        req_valid[i]     = (dq[i].size() != 0) && (!gaps || $urandom_range(0, 2) != 0);
        req_data[8*i+:8] = (dq[i].size() != 0) ? dq[i][0] : 8'h00;
        req_last[i]      = (lq[i].size() != 0) ? lq[i][0] : 1'b0;
      end
      #1;
      checks++;
      if (tx_start !== pend || (pend && (tx_data !== pend_byte || grant_id !== pend_id[ID_W-1:0]))) begin
        errors++;
        $display("FAIL %s_start: tx_start=%b tx_data=%h grant_id=%0d, need %b %h %0d",
                 name, tx_start, tx_data, grant_id, pend, pend_byte, pend_id);
      end
      checks++;
      if (tx_start === 1'b1 && tx_busy === 1'b1) begin
        errors++;
        $display("FAIL %s_start_while_busy: tx_start=1 tx_busy=1, need tx_start=0", name);
      end
      checks++;
      if (active !== m_out) begin
        errors++;
        $display("FAIL %s_active: active=%b, need %b", name, active, m_out);
      end
      pend = 0;
      elig = req_valid;
      if (m_locked) elig = req_valid & (NUM_REQ'(1) << m_lock);
      exp_w = -1;
      if (!m_out && !tx_busy) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (m_ptr + k) % NUM_REQ;
          if (exp_w < 0 && elig[idx]) exp_w = idx;
        end
      end
      exp_ready = (exp_w >= 0) ? (NUM_REQ'(1) << exp_w) : '0;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL %s_req_ready: req_ready=%b, need %b", name, req_ready, exp_ready);
      end
      if (m_out) begin
        if (m_seen && !tx_busy) m_out = 0;
        if (tx_busy) m_seen = 1;
      end
      if (exp_w >= 0) begin
        pend = 1; pend_id = exp_w;
        pend_byte = dq[exp_w].pop_front();
        lastb = lq[exp_w].pop_front();
        glog.push_back(exp_w);
        dlog.push_back(pend_byte);
        m_out = 1; m_seen = 0;
`ifdef UART_TX_ARB_LOCK_EN
        if (lastb) begin m_locked = 0; m_ptr = (exp_w + 1) % NUM_REQ; end
        else begin m_locked = 1; m_lock = exp_w; end
`else
        if (lastb) m_ptr = (exp_w + 1) % NUM_REQ;
        else m_ptr = (exp_w + 1) % NUM_REQ;
`endif
      end
      done = !pend && !m_out;
      for (int i = 0; i < NUM_REQ; i++) if (dq[i].size() != 0) done = 0;
    end
    req_valid = '0;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: traffic not drained in %0d cycles, need drained", name, budget);
    end
  endtask

  task automatic test_reset;
    req_valid = 4'hF; req_data = 32'h13121110; req_last = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    checks++;
    if ({tx_start, tx_data, grant_id, active, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b data=%h gid=%0d active=%b ready=%b, need all 0",
               tx_start, tx_data, grant_id, active, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;
    m_ptr = 0; m_locked = 0; m_out = 0; m_seen = 0;
    @(posedge clk); #1;
    req_valid = 4'b0100; req_data = 32'h00A50000; req_last = 4'b0100; #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready: req_ready=%b, need 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0; #1;
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5 || grant_id !== 2'd2 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_start: start=%b data=%h gid=%0d ready=%b, need 1 a5 2 0000",
               tx_start, tx_data, grant_id, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (tx_start !== 1'b0) begin
      errors++; $display("FAIL single_pulse_width: tx_start=%b, need 0", tx_start);
    end
    wait_idle("single", 100);
    m_ptr = 3;
  endtask

  task automatic test_rotation;
    int exp_g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    glog.delete(); dlog.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      dq[i] = '{8'h10 + 8'(i), 8'h14 + 8'(i)};
      lq[i] = '{1'b1, 1'b1};
    end
    run_traffic("rotation", 600);
    checks++;
    if (glog.size() != 8) begin
      errors++; $display("FAIL rotation_count: grants=%0d, need 8", glog.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (glog[j] != exp_g[j] || dlog[j] !== 8'h10 + 8'(j)) begin
          errors++;
          $display("FAIL rotation_order[%0d]: grant=%0d byte=%h, need %0d %h", j, glog[j], dlog[j], exp_g[j], 8'h10 + 8'(j));
        end
      end
    end
  endtask

  task automatic test_pointer_skip;
    do_reset();
    dq[1] = '{8'h21}; lq[1] = '{1'b1};
    run_traffic("skip_setup", 200);
    glog.delete(); dlog.delete();
    dq[1] = '{8'h22}; lq[1] = '{1'b1};
    dq[3] = '{8'h33}; lq[3] = '{1'b1};
    run_traffic("skip", 300);
    checks++;
    if (glog.size() != 2 || glog[0] != 3 || glog[1] != 1) begin
      errors++;
      $display("FAIL pointer_skip: grants=%0d first=%0d, need 2 grants 3 then 1", glog.size(), glog.size() > 0 ? glog[0] : -1);
    end
  endtask

  task automatic test_reset_midframe;
    int n;
    do_reset();
    req_valid = 4'b0001; req_data = 32'h0000005A; req_last = 4'b0001;
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    while (tx_busy !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    repeat (8) @(posedge clk);
    #1 rst = 1'b1; #1;
    checks++;
    if ({tx_start, tx_data, grant_id, active, req_ready} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: start=%b data=%h gid=%0d active=%b ready=%b, need all 0",
               tx_start, tx_data, grant_id, active, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 0; m_locked = 0; m_out = 0; m_seen = 0;
    glog.delete(); dlog.delete();
    dq[1] = '{8'h77}; lq[1] = '{1'b1};
    run_traffic("midframe", 300);
    checks++;
    if (glog.size() != 1 || dlog[0] !== 8'h77) begin
      errors++; $display("FAIL midframe_resume: grants=%0d, need one grant of 77", glog.size());
    end
  endtask

  task automatic test_lock;
`ifdef UART_TX_ARB_LOCK_EN
    int exp_g[6] = '{0, 0, 0, 1, 1, 1};
    logic [7:0] exp_d[6] = '{8'h41, 8'h42, 8'h43, 8'h50, 8'h51, 8'h52};
`else
    int exp_g[6] = '{0, 1, 0, 1, 0, 1};
    logic [7:0] exp_d[6] = '{8'h41, 8'h50, 8'h42, 8'h51, 8'h43, 8'h52};
`endif
    do_reset();
    glog.delete(); dlog.delete();
    dq[0] = '{8'h41, 8'h42, 8'h43}; lq[0] = '{1'b0, 1'b0, 1'b1};
    dq[1] = '{8'h50, 8'h51, 8'h52}; lq[1] = '{1'b1, 1'b1, 1'b1};
    run_traffic("lock", 600);
    checks++;
    if (glog.size() != 6) begin
      errors++; $display("FAIL lock_count: grants=%0d, need 6", glog.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        checks++;
        if (glog[j] != exp_g[j] || dlog[j] !== exp_d[j]) begin
          errors++;
          $display("FAIL lock_order[%0d]: grant=%0d byte=%h, need %0d %h", j, glog[j], dlog[j], exp_g[j], exp_d[j]);
        end
      end
    end
  endtask

  task automatic test_random;
    int len;
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) do_reset();
      gaps = 1;
      for (int i = 0; i < NUM_REQ; i++) begin
        dq[i].delete(); lq[i].delete();
        len = $urandom_range(0, 3);
        for (int b = 0; b < len; b++) begin
          dq[i].push_back(8'($urandom));
          lq[i].push_back((b == len - 1) ? 1'b1 : 1'($urandom));
        end
      end
      run_traffic("random", 3000);
      gaps = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; gaps = 0;
    m_ptr = 0; m_lock = 0; m_locked = 0; m_out = 0; m_seen = 0;
    test_reset();
    test_rotation();
    test_pointer_skip();
    test_reset_midframe();
    test_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
